// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and
// presents one registered instruction per cycle to decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] inst_read_addr,
    input  logic [31:0] inst_code,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        redirect_is_jalr,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [32:0] PC_LIMIT = 33'(ROM_DEPTH) * 33'd4;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic        target_ok;
    logic        pc_ok;
    logic        slot_free;

    assign inst_read_addr = pc;

    // Widen to 33 bits so the range check cannot wrap near 2^32.
    always_comb begin
        target    = redirect_target & ~{31'b0, redirect_is_jalr};
        target_ok = (target[1:0] == 2'b00) && ({1'b0, target} < PC_LIMIT);
        pc_ok     = (pc[1:0] == 2'b00) && ({1'b0, pc} < PC_LIMIT);
        slot_free = !if_valid || if_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_inst     <= NOP;
            if_pc       <= 32'h0000_0000;
            if_pc_plus4 <= 32'h0000_0004;
            fault       <= 1'b0;
            fault_pc    <= 32'h0000_0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                        if (target_ok) begin
                            pc <= target;
                        end else begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            fault_pc <= target;
                        end
                    end else if (slot_free) begin
                        if (pc_ok) begin
                            if_inst     <= inst_code;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc + 32'd4;
                            if_valid    <= 1'b1;
                            pc          <= pc + 32'd4;
                        end else begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            fault_pc <= pc;
                            if_valid <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    // A leftover instruction may still drain to decode.
                    if (if_valid && if_ready) begin
                        if_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level instruction-stream model.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] inst_read_addr;
    logic [31:0] inst_code;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_is_jalr;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] rom [1024];
    int tests;
    int failed;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ROM_DEPTH(1024)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .inst_read_addr  (inst_read_addr),
        .inst_code       (inst_code),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .redirect_is_jalr(redirect_is_jalr),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    assign inst_code = rom[inst_read_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        redirect_is_jalr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Leaves the bench at the negedge where the RESET_PC instruction is shown.
    task automatic start_run(input logic rdy);
        do_reset();
        fetch_en = 1'b1;
        if_ready = rdy;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (if_valid !== 1'b0 || inst_read_addr !== 32'h0) begin
                failed++;
                $display("FAIL reset_idle cyc%0d: valid=%b addr=%h, want 0/0",
                         i, if_valid, inst_read_addr);
            end
            @(negedge clk);
        end
        tests++;
        if (if_inst !== 32'h13 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
            failed++;
            $display("FAIL reset_slot: inst=%h pc=%h p4=%h, want 13/0/4",
                     if_inst, if_pc, if_pc_plus4);
        end
        tests++;
        if (fault !== 1'b0 || fault_pc !== 32'h0) begin
            failed++;
            $display("FAIL reset_fault: fault=%b fault_pc=%h, want 0/0", fault, fault_pc);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b0) begin
            failed++;
            $display("FAIL seq_e0: valid=%b, want 0", if_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) ||
                if_inst !== 32'(32'hA0 + i) || if_pc_plus4 !== 32'(4 * i + 4)) begin
                failed++;
                $display("FAIL seq_%0d: v=%b pc=%h inst=%h p4=%h, want 1/%h/%h/%h",
                         i, if_valid, if_pc, if_inst, if_pc_plus4,
                         4 * i, 32'hA0 + i, 4 * i + 4);
            end
        end
    endtask

    task automatic test_backpressure();
        start_run(1'b1);
        @(negedge clk);
        @(negedge clk);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'hA2 ||
                if_pc_plus4 !== 32'hC || inst_read_addr !== 32'hC) begin
                failed++;
                $display("FAIL stall_%0d: v=%b pc=%h inst=%h p4=%h addr=%h, want 1/8/a2/c/c",
                         i, if_valid, if_pc, if_inst, if_pc_plus4, inst_read_addr);
            end
        end
        if_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'hC || if_inst !== 32'hA3) begin
            failed++;
            $display("FAIL stall_release: v=%b pc=%h inst=%h, want 1/c/a3",
                     if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_branch_redirect();
        start_run(1'b1);
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        redirect_is_jalr = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++;
        if (if_valid !== 1'b0 || inst_read_addr !== 32'h40) begin
            failed++;
            $display("FAIL redir_bubble: v=%b addr=%h, want 0/40", if_valid, inst_read_addr);
        end
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== rom[16]) begin
            failed++;
            $display("FAIL redir_target: v=%b pc=%h inst=%h, want 1/40/%h",
                     if_valid, if_pc, if_inst, rom[16]);
        end
    endtask

    task automatic test_jalr();
        logic [31:0] held;
        start_run(1'b1);
        redirect_valid = 1'b1;
        redirect_target = 32'h8D;
        redirect_is_jalr = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_is_jalr = 1'b0;
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8C || if_inst !== rom[35]) begin
            failed++;
            $display("FAIL jalr_clear: v=%b pc=%h inst=%h, want 1/8c/%h",
                     if_valid, if_pc, if_inst, rom[35]);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h8E;
        @(negedge clk);
        redirect_valid = 1'b0;
        held = inst_read_addr;
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'h8E || if_valid !== 1'b0) begin
            failed++;
            $display("FAIL jalr_misalign: fault=%b fpc=%h v=%b, want 1/8e/0",
                     fault, fault_pc, if_valid);
        end
        tests++;
        if (held !== 32'h90) begin
            failed++;
            $display("FAIL jalr_pc_at_fault: addr=%h, want 90", held);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (inst_read_addr !== 32'h90 || fault !== 1'b1 || if_valid !== 1'b0) begin
            failed++;
            $display("FAIL jalr_frozen: addr=%h fault=%b v=%b, want 90/1/0",
                     inst_read_addr, fault, if_valid);
        end
    endtask

    task automatic test_range_fault();
        start_run(1'b1);
        redirect_valid = 1'b1;
        redirect_target = 32'hFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (if_valid !== 1'b1 || if_pc !== 32'(32'hFF8 + 4 * i) ||
                if_inst !== rom[1022 + i] || fault !== 1'b0) begin
                failed++;
                $display("FAIL range_deliver_%0d: v=%b pc=%h inst=%h fault=%b",
                         i, if_valid, if_pc, if_inst, fault);
            end
        end
        @(negedge clk);
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'h1000 || if_valid !== 1'b0) begin
            failed++;
            $display("FAIL range_fault: fault=%b fpc=%h v=%b, want 1/1000/0",
                     fault, fault_pc, if_valid);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (inst_read_addr !== 32'h1000 || if_valid !== 1'b0 ||
            fault !== 1'b1 || fault_pc !== 32'h1000) begin
            failed++;
            $display("FAIL range_ignore_redir: addr=%h v=%b fault=%b fpc=%h",
                     inst_read_addr, if_valid, fault, fault_pc);
        end
    endtask

    task automatic test_mid_stall_reset();
        start_run(1'b0);
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            failed++;
            $display("FAIL mreset_pre: v=%b pc=%h, want 1/0", if_valid, if_pc);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fetch_en = 1'b0;
        tests++;
        if (if_valid !== 1'b0 || if_inst !== 32'h13 || inst_read_addr !== 32'h0 ||
            fault !== 1'b0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
            failed++;
            $display("FAIL mreset_vals: v=%b inst=%h addr=%h fault=%b pc=%h p4=%h",
                     if_valid, if_inst, inst_read_addr, fault, if_pc, if_pc_plus4);
        end
        if_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (if_valid !== 1'b0 || inst_read_addr !== 32'h0) begin
            failed++;
            $display("FAIL mreset_idle: v=%b addr=%h, want 0/0", if_valid, inst_read_addr);
        end
        fetch_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== rom[0]) begin
            failed++;
            $display("FAIL mreset_restart: v=%b pc=%h inst=%h", if_valid, if_pc, if_inst);
        end
    endtask

    // Model: the stream decode accepts is sequential from the last redirect
    // target, every word matches the ROM, and a stalled slot never changes.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] s_pc;
        logic [31:0] s_inst;
        logic [31:0] s_addr;
        logic        prev_stall;
        logic        prev_redir;
        logic [31:0] t;
        int          accepted;
        exp_pc = 32'h0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        accepted = 0;
        s_pc = '0;
        s_inst = '0;
        s_addr = '0;
        start_run(1'b1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (prev_stall) begin
                tests++;
                if (if_valid !== 1'b1 || if_pc !== s_pc || if_inst !== s_inst ||
                    inst_read_addr !== s_addr) begin
                    failed++;
                    $display("FAIL rnd_hold c%0d: v=%b pc=%h/%h inst=%h/%h addr=%h/%h",
                             cyc, if_valid, if_pc, s_pc, if_inst, s_inst,
                             inst_read_addr, s_addr);
                end
            end
            if (prev_redir) begin
                tests++;
                if (if_valid !== 1'b0) begin
                    failed++;
                    $display("FAIL rnd_bubble c%0d: v=%b, want 0", cyc, if_valid);
                end
            end
            if (fault !== 1'b0) begin
                tests++;
                failed++;
                $display("FAIL rnd_fault c%0d: fault=%b fpc=%h, want 0", cyc, fault, fault_pc);
            end
            if_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0) || (exp_pc >= 32'hF00);
            redirect_is_jalr = $urandom_range(0, 1) == 1;
            t = 32'($urandom_range(0, 32'h7FF)) & 32'hFFFF_FFFC;
            redirect_target = redirect_is_jalr ? (t | 32'($urandom_range(0, 1))) : t;
            if (if_valid && if_ready) begin
                tests++;
                accepted++;
                if (if_pc !== exp_pc || if_inst !== rom[exp_pc[11:2]] ||
                    if_pc_plus4 !== exp_pc + 32'd4) begin
                    failed++;
                    $display("FAIL rnd_accept c%0d: pc=%h inst=%h p4=%h, want %h/%h/%h",
                             cyc, if_pc, if_inst, if_pc_plus4,
                             exp_pc, rom[exp_pc[11:2]], exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = t;
            prev_stall = if_valid && !if_ready && !redirect_valid;
            prev_redir = redirect_valid;
            s_pc = if_pc;
            s_inst = if_inst;
            s_addr = inst_read_addr;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++;
        if (accepted < 100) begin
            failed++;
            $display("FAIL rnd_liveness: accepted=%0d, want >=100", accepted);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        redirect_is_jalr = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        for (int i = 0; i < 4; i++) rom[i] = 32'(32'hA0 + i);
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_redirect();
        test_jalr();
        test_range_fault();
        test_mid_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the instruction ROM. Owns the program counter, drives the ROM word address, and registers the returned instruction into a valid/ready output slot for decode. Also accepts branch and jump redirects from execute. Raises a sticky fault on a misaligned or out-of-range fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ROM_DEPTH, 1024, instruction ROM size in 32-bit words; legal fetch range is [0, ROM_DEPTH*4).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- fetch_en  in  1  leaves IDLE when sampled 1.
- inst_read_addr  out  32  byte address to the ROM; equals the PC register.
- inst_code  in  32  ROM data for inst_read_addr, combinational in the same cycle.
- if_valid  out  1  output slot holds an instruction.
- if_ready  in  1  decode accepts the slot this cycle.
- if_inst  out  32  registered instruction.
- if_pc  out  32  PC of if_inst.
- if_pc_plus4  out  32  if_pc + 4, mod 2^32.
- redirect_valid  in  1  execute requests a PC change.
- redirect_target  in  32  new PC.
- redirect_is_jalr  in  1  clear bit 0 of the target before use (JALR rule).
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  offending address, captured when the fault occurs.

## Operation
- The FSM has three states: IDLE, RUN and FAULT.
  - IDLE → RUN when fetch_en = 1.
  - RUN → FAULT on a bad fetch or a bad redirect.
  - FAULT is exited only by reset.
- Reset, when reset = 0 at a clock edge:
  - state = IDLE, pc = RESET_PC, if_valid = 0.
  - if_inst = 32'h0000_0013 (NOP), if_pc = 0, if_pc_plus4 = 4.
  - fault = 0, fault_pc = 0.
- The slot is "free" when if_valid = 0, or when if_valid = 1 and if_ready = 1.
- In RUN, with no redirect and the slot free:
  - Capture inst_code → if_inst, pc → if_pc, pc+4 → if_pc_plus4.
  - Set if_valid = 1 and advance pc <= pc + 4.
- In RUN, with the slot not free: pc and the slot hold unchanged.
- Redirect (RUN only) has the highest priority:
  - The effective target t is redirect_target, with bit 0 cleared if redirect_is_jalr = 1.
  - If t[1:0] == 0 and t < ROM_DEPTH*4: pc <= t and if_valid <= 0, so no stale instruction is presented. No capture occurs that cycle.
  - Otherwise: go to FAULT, fault <= 1, fault_pc <= t, if_valid <= 0.
  - A handshake (if_valid & if_ready) in the same cycle as a redirect still counts as consumed.
- Bad fetch: in RUN with the slot free and pc >= ROM_DEPTH*4, go to FAULT, fault <= 1, fault_pc <= pc, and do not capture.
  - An instruction already in the slot remains valid until it is consumed, then if_valid = 0.
- FAULT: pc frozen, redirects ignored, no captures.
- In IDLE: no captures and redirects ignored. inst_read_addr = RESET_PC.
- Arithmetic: all PC math is 32-bit unsigned, wrapping.

## Timing
- inst_read_addr is a register output; inst_code is sampled at the same edge at which pc advances.
- First instruction: fetch_en sampled at edge E0 → RUN. The RESET_PC instruction is captured at E1, and if_valid is high after E1.
- Throughput is 1 instruction per cycle while if_ready = 1; there are no bubbles on sequential flow.
- Redirect penalty:
  - redirect_valid sampled at edge R makes if_valid = 0 after R, and inst_read_addr = t after R.
  - The target instruction is valid after R+1.
- Backpressure: while if_valid = 1 and if_ready = 0, if_inst, if_pc and if_pc_plus4 are stable and inst_read_addr does not change.
- The fault flag asserts the cycle after the offending edge and stays high until reset.
- Reset mid-operation: all outputs take their reset values after the first edge with reset = 0, regardless of state or handshake.

## Test plan
- Sequential run:
  - Stimulus: ROM words 0..3 = 0xA0..0xA3, reset released, fetch_en = 1 at E0, if_ready = 1.
  - Response: if_valid rises after E1, then if_pc = 0, 4, 8, 12 with if_inst = 0xA0..0xA3 on consecutive cycles.
- Backpressure:
  - Stimulus: if_ready = 0 for 3 cycles while if_pc = 8.
  - Response: if_pc, if_inst and inst_read_addr = 0xC are held. After if_ready = 1, if_pc = 8 is accepted, then if_pc = 0xC follows with no gap and no duplicate.
- Branch redirect:
  - Stimulus: redirect to 0x40 while if_valid = 1.
  - Response: one cycle with if_valid = 0, then if_pc = 0x40 with if_inst = ROM[16]. The old next PC never appears.
- JALR rule:
  - Stimulus 1: redirect_target 0x8D with is_jalr = 1. Response: if_pc = 0x8C.
  - Stimulus 2: redirect_target 0x8E. Response: fault = 1, fault_pc = 0x8E, if_valid = 0, pc frozen.
- Range fault:
  - Stimulus: with ROM_DEPTH = 1024, redirect to 0xFF8 and run with if_ready = 1.
  - Response: if_pc = 0xFF8 then 0xFFC are delivered, then fault = 1 with fault_pc = 0x1000. A later redirect is ignored.
- Mid-stall reset:
  - Stimulus: reset = 0 for one edge while if_valid = 1 and if_ready = 0.
  - Response: if_valid = 0, if_inst = 0x13, inst_read_addr = RESET_PC, fault = 0, state IDLE until fetch_en = 1.
